// File: rtl/uart_rxd_ctrl.sv
// 8N1 UART receiver: two-flop synchroniser, own bit timer, 2-of-3 mid-bit majority vote.
// Emits the received byte with a one-cycle complete strobe, or a one-cycle framing-error strobe.
module uart_rxd_ctrl #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic [7:0] read_value,
   output logic       read_complete,
   output logic       read_error,
   output logic       busy
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SMP0     = CW'(HALF - 1);
   localparam logic [CW-1:0] SMP1     = CW'(HALF);
   localparam logic [CW-1:0] DECIDE   = CW'(HALF + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    smp_q, smp_d;
   logic [7:0]    value_q, value_d;
   logic          complete_q, complete_d;
   logic          error_q, error_d;
   logic          busy_q, busy_d;
   logic          rx_s, maj;

   always_comb begin
      rx_s       = sync_q[1];
      // third vote is the live sample taken at the decision point
      maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
      sync_d     = {sync_q[0], uart_rxd};
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      smp_d      = smp_q;
      value_d    = value_q;
      complete_d = 1'b0;
      error_d    = 1'b0;

      if (state_q == START || state_q == DATA || state_q == STOP) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         if (cnt_q == SMP0) smp_d[0] = rx_s;
         if (cnt_q == SMP1) smp_d[1] = rx_s;
      end

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == DECIDE && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = DATA;
               bit_idx_d = 3'd0;
            end
         end
         DATA: begin
            if (cnt_q == DECIDE) shift_d = {maj, shift_q[7:1]};
            if (cnt_q == CNT_LAST) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // leave at mid stop bit so a start bit right after it is not missed
            if (cnt_q == DECIDE) begin
               cnt_d = '0;
               if (maj) begin
                  state_d    = IDLE;
                  value_d    = shift_q;
                  complete_d = 1'b1;
               end else begin
                  state_d = BREAK_WAIT;
                  error_d = 1'b1;
               end
            end
         end
         BREAK_WAIT: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         cnt_q      <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         smp_q      <= 2'b00;
         value_q    <= 8'h00;
         complete_q <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         smp_q      <= smp_d;
         value_q    <= value_d;
         complete_q <= complete_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
      end
   end

   assign read_value    = value_q;
   assign read_complete = complete_q;
   assign read_error    = error_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_uart_rxd_ctrl.sv
// Directed bench for uart_rxd_ctrl at 16 clocks per bit.
module tb_uart_rxd_ctrl;
   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clk_50M = 1'b0;
   logic       reset;
   logic       uart_rxd;
   logic [7:0] read_value;
   logic       read_complete, read_error, busy;

   uart_rxd_ctrl #(.CLKS_PER_BIT(CPB)) dut (
      .clk_50M(clk_50M), .reset(reset), .uart_rxd(uart_rxd),
      .read_value(read_value), .read_complete(read_complete),
      .read_error(read_error), .busy(busy)
   );

   always #5 clk_50M = ~clk_50M;

   int vecs = 0;
   int errs = 0;

   int cyc = 0;
   always @(posedge clk_50M) cyc <= cyc + 1;

   // pulse monitor, sampled on the falling edge
   int         n_cpl = 0, n_err = 0, cpl_cyc = 0, busy_cyc = 0, overlap = 0;
   logic       prev_pulse = 1'b0;
   logic       busy_at_cpl = 1'b1;
   logic [7:0] cpl_vals[$];
   always @(negedge clk_50M) begin
      if (read_complete) begin
         n_cpl++;
         cpl_cyc = cyc;
         busy_at_cpl = busy;
         cpl_vals.push_back(read_value);
      end
      if (read_error) n_err++;
      if (busy) busy_cyc++;
      if ((read_complete || read_error) && prev_pulse) overlap++;
      if (read_complete && read_error) overlap++;
      prev_pulse = read_complete || read_error;
   end

   int stop_edge;

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      repeat (CPB) @(posedge clk_50M);
      #1;
   endtask

   // glitch < 0 means none; otherwise that data bit is inverted for one cycle at cnt=HALF
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            uart_rxd = b[i];
            repeat (HALF + 1) @(posedge clk_50M);
            #1 uart_rxd = ~b[i];
            @(posedge clk_50M);
            #1 uart_rxd = b[i];
            repeat (CPB - HALF - 2) @(posedge clk_50M);
            #1;
         end else begin
            drive_bit(b[i]);
         end
      end
      stop_edge = cyc + 1;
      drive_bit(stop_v);
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      uart_rxd = 1'b1;
      repeat (2) @(posedge clk_50M);
      #1;
      vecs++;
      if ({read_value, read_complete, read_error, busy} !== 11'd0) begin
         errs++;
         $display("FAIL reset_state: got val=%h cpl=%b err=%b busy=%b, want all 0",
                  read_value, read_complete, read_error, busy);
      end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_single_frame;
      int c0 = n_cpl;
      int e0 = n_err;
      send_frame(8'hA5, 1'b1, -1);
      idle(4);
      vecs++;
      if (read_value !== 8'hA5) begin
         errs++; $display("FAIL a5_value: got %h want a5", read_value);
      end
      vecs++;
      if (n_cpl - c0 !== 1) begin
         errs++; $display("FAIL a5_cpl_count: got %0d want 1", n_cpl - c0);
      end
      vecs++;
      if (cpl_cyc - stop_edge !== 2 + HALF + 1 + 1) begin
         errs++; $display("FAIL a5_latency: got %0d want %0d", cpl_cyc - stop_edge, 2 + HALF + 2);
      end
      vecs++;
      if (n_err - e0 !== 0) begin
         errs++; $display("FAIL a5_no_error: got %0d errors want 0", n_err - e0);
      end
      vecs++;
      if (busy_at_cpl !== 1'b0 || busy !== 1'b0) begin
         errs++; $display("FAIL a5_busy: got busy_at_pulse=%b busy=%b want 0 0", busy_at_cpl, busy);
      end
   endtask

   task automatic test_false_start;
      int c0 = n_cpl;
      int e0 = n_err;
      int b0 = busy_cyc;
      uart_rxd = 1'b0;
      repeat (4) @(posedge clk_50M);
      #1;
      idle(40);
      vecs++;
      if (busy_cyc - b0 < 1 || busy_cyc - b0 > 2 + 9) begin
         errs++; $display("FAIL false_start_busy: got %0d busy cycles want 1..11", busy_cyc - b0);
      end
      vecs++;
      if (n_cpl - c0 !== 0 || n_err - e0 !== 0 || busy !== 1'b0) begin
         errs++; $display("FAIL false_start_pulses: got cpl=%0d err=%0d busy=%b want 0 0 0",
                          n_cpl - c0, n_err - e0, busy);
      end
      vecs++;
      if (read_value !== 8'hA5) begin
         errs++; $display("FAIL false_start_value: got %h want a5", read_value);
      end
   endtask

   task automatic test_framing_error;
      int c0 = n_cpl;
      int e0 = n_err;
      send_frame(8'h3C, 1'b0, -1);
      uart_rxd = 1'b0;
      repeat (40) @(posedge clk_50M);
      #1;
      vecs++;
      if (n_err - e0 !== 1 || n_cpl - c0 !== 0) begin
         errs++; $display("FAIL ferr_pulses: got err=%0d cpl=%0d want 1 0", n_err - e0, n_cpl - c0);
      end
      vecs++;
      if (read_value !== 8'hA5 || busy !== 1'b1) begin
         errs++; $display("FAIL ferr_break: got val=%h busy=%b want a5 1", read_value, busy);
      end
      idle(20);
      vecs++;
      if (busy !== 1'b0 || n_err - e0 !== 1) begin
         errs++; $display("FAIL ferr_recover: got busy=%b err=%0d want 0 1", busy, n_err - e0);
      end
      send_frame(8'h81, 1'b1, -1);
      idle(4);
      vecs++;
      if (read_value !== 8'h81 || n_cpl - c0 !== 1) begin
         errs++; $display("FAIL ferr_next: got val=%h cpl=%0d want 81 1", read_value, n_cpl - c0);
      end
   endtask

   task automatic test_back_to_back;
      int e0 = n_err;
      cpl_vals.delete();
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      idle(4);
      vecs++;
      if (cpl_vals.size() !== 2) begin
         errs++; $display("FAIL b2b_count: got %0d pulses want 2", cpl_vals.size());
      end else begin
         vecs++;
         if (cpl_vals[0] !== 8'h00 || cpl_vals[1] !== 8'hFF) begin
            errs++; $display("FAIL b2b_values: got %h %h want 00 ff", cpl_vals[0], cpl_vals[1]);
         end
      end
      vecs++;
      if (n_err - e0 !== 0) begin
         errs++; $display("FAIL b2b_no_error: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_glitch;
      int c0 = n_cpl;
      send_frame(8'h55, 1'b1, 2);
      idle(4);
      vecs++;
      if (read_value !== 8'h55 || n_cpl - c0 !== 1) begin
         errs++; $display("FAIL glitch_filter: got val=%h cpl=%0d want 55 1", read_value, n_cpl - c0);
      end
   endtask

   task automatic test_mid_frame_reset;
      logic [7:0] b;
      int         c0, e0;
      b = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      uart_rxd = b[3];
      repeat (5) @(posedge clk_50M);
      #1 reset = 1'b1;
      uart_rxd = 1'b1;
      #1;
      vecs++;
      if ({read_value, read_complete, read_error, busy} !== 11'd0) begin
         errs++; $display("FAIL reset_async: got val=%h cpl=%b err=%b busy=%b want all 0",
                          read_value, read_complete, read_error, busy);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_50M);
         vecs++;
         if ({read_value, read_complete, read_error, busy} !== 11'd0) begin
            errs++; $display("FAIL reset_hold: got val=%h cpl=%b err=%b busy=%b want all 0",
                             read_value, read_complete, read_error, busy);
         end
      end
      @(posedge clk_50M);
      #1 reset = 1'b0;
      idle(20);
      c0 = n_cpl;
      e0 = n_err;
      send_frame(8'h96, 1'b1, -1);
      idle(4);
      vecs++;
      if (read_value !== 8'h96 || n_cpl - c0 !== 1 || n_err - e0 !== 0) begin
         errs++; $display("FAIL reset_recover: got val=%h cpl=%0d err=%0d want 96 1 0",
                          read_value, n_cpl - c0, n_err - e0);
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_false_start;
      test_framing_error;
      test_back_to_back;
      test_glitch;
      test_mid_frame_reset;
      vecs++;
      if (overlap !== 0) begin
         errs++; $display("FAIL strobe_spacing: got %0d adjacent/overlapping strobes want 0", overlap);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
